// File: rtl/ula_controller.sv
// ula_controller: request/response sequencer for the 8-bit-in / 16-bit-out ULA.
// Accepts one operation at a time. Logic and add/sub complete in one cycle;
// multiply runs an 8-iteration shift-add loop. The result and the flag
// register are owned here and change only when an operation completes.
module ula_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] result,
  output logic        zero_flag,
  output logic        sign_flag,
  output logic        carry_flag,
  output logic        overflow_flag,
  output logic        busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Multiply working registers, loaded when a request is accepted
  logic [7:0]  mcand_q;
  logic [7:0]  mplier_q;
  logic [15:0] acc_q;
  logic [2:0]  cnt_q;

  // Registered result and flags
  logic [15:0] result_q;
  logic        zero_q;
  logic        sign_q;
  logic        carry_q;
  logic        ovf_q;

  // Single-cycle ALU outputs
  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_ovf;

  // Shift-add step and completion load controls
  logic [15:0] partial;
  logic [15:0] acc_next;
  logic        accept;
  logic        load_en;
  logic [15:0] load_value;
  logic        load_carry;
  logic        load_ovf;

  assign accept = (state_q == IDLE) && req_valid;

  // Single-cycle operations are evaluated straight from the request inputs
  always_comb begin
    sum9       = {1'b0, a} + {1'b0, b};
    diff9      = {1'b0, a} - {1'b0, b};
    alu_result = 16'h0000;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        alu_result = {7'b0, sum9};
        alu_carry  = sum9[8];
        alu_ovf    = (a[7] == b[7]) && (sum9[7] != a[7]);
      end
      OP_SUB: begin
        alu_result = {{7{diff9[8]}}, diff9};
        alu_carry  = diff9[8];
        alu_ovf    = (a[7] != b[7]) && (diff9[7] != a[7]);
      end
      OP_AND:  alu_result = {8'h00, a & b};
      OP_OR:   alu_result = {8'h00, a | b};
      OP_XOR:  alu_result = {8'h00, a ^ b};
      default: alu_result = 16'h0000;
    endcase
  end

  // One multiply iteration: add the multiplicand shifted by the current bit index
  always_comb begin
    partial  = 16'h0000;
    if (mplier_q[cnt_q]) begin
      partial = {8'h00, mcand_q} << cnt_q;
    end
    acc_next = acc_q + partial;
  end

  // Next-state logic and selection of the value loaded at completion
  always_comb begin
    state_d    = state_q;
    load_en    = 1'b0;
    load_value = 16'h0000;
    load_carry = 1'b0;
    load_ovf   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (op == OP_MUL) begin
            state_d = MUL_RUN;
          end else begin
            state_d    = DONE;
            load_en    = 1'b1;
            load_value = alu_result;
            load_carry = alu_carry;
            load_ovf   = alu_ovf;
          end
        end
      end
      MUL_RUN: begin
        if (cnt_q == 3'd7) begin
          state_d    = DONE;
          load_en    = 1'b1;
          load_value = acc_next;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Multiply operands, accumulator and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= 8'h00;
      mplier_q <= 8'h00;
      acc_q    <= 16'h0000;
      cnt_q    <= 3'd0;
    end else if (accept) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= 16'h0000;
      cnt_q    <= 3'd0;
    end else if (state_q == MUL_RUN) begin
      acc_q    <= acc_next;
      cnt_q    <= cnt_q + 3'd1;
    end
  end

  // Result and flag register, written only when an operation completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 16'h0000;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load_en) begin
      result_q <= load_value;
      zero_q   <= (load_value == 16'h0000);
      sign_q   <= load_value[15];
      carry_q  <= load_carry;
      ovf_q    <= load_ovf;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign result        = result_q;
  assign zero_flag     = zero_q;
  assign sign_flag     = sign_q;
  assign carry_flag    = carry_q;
  assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_ula_controller.sv
// tb_ula_controller: directed and randomized stimulus for ula_controller with
// a queue-based scoreboard; a monitor pops expected responses at each handshake.
module tb_ula_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  op = 3'd0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] result;
  logic        zero_flag;
  logic        sign_flag;
  logic        carry_flag;
  logic        overflow_flag;
  logic        busy;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        v;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  logic forced_ready = 1'b0;
  logic prev_valid = 1'b0;

  ula_controller dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .op(op),
    .a(a),
    .b(b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .result(result),
    .zero_flag(zero_flag),
    .sign_flag(sign_flag),
    .carry_flag(carry_flag),
    .overflow_flag(overflow_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure response latency
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: either random backpressure or a directed level
  always @(posedge clk) begin
    #2;
    rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference behaviour from plain integer arithmetic
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   ux, uy, sx, sy, r;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > 127) ? ux - 256 : ux;
    sy = (uy > 127) ? uy - 256 : uy;
    e.res = 16'h0000;
    e.c = 1'b0;
    e.v = 1'b0;
    e.lat = 0;
    e.acc_cyc = 0;
    case (o)
      3'd0: begin
        r = ux + uy;
        e.res = r[15:0];
        e.c = (r > 255);
        e.v = ((sx + sy) > 127) || ((sx + sy) < -128);
      end
      3'd1: begin
        r = ux - uy;
        e.res = r[15:0];
        e.c = (ux < uy);
        e.v = ((sx - sy) > 127) || ((sx - sy) < -128);
      end
      3'd2: begin r = ux & uy; e.res = r[15:0]; end
      3'd3: begin r = ux | uy; e.res = r[15:0]; end
      3'd4: begin r = ux ^ uy; e.res = r[15:0]; end
      3'd5: begin r = ux * uy; e.res = r[15:0]; e.lat = 8; end
      default: e.res = 16'h0000;
    endcase
    return e;
  endfunction

  // Issue one request (called 1 time unit after a rising edge) and record its expectation
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   n;
    n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checkOutput("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    op = o;
    a = x;
    b = y;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e = model(o, x, y);
    e.acc_cyc = cyc;
    sb.push_back(e);
  endtask

  // Wait until every expected response has been consumed
  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 32'd0);
  endtask

  // Monitor: latency on first presentation, full compare at each handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (rsp_valid && sb.size() == 0) begin
          checkOutput("unexpected_response", 32'd1, 32'd0);
        end else if (rsp_valid) begin
          if (!prev_valid) checkOutput("latency", cyc - sb[0].acc_cyc, sb[0].lat);
          if (rsp_ready) begin
            e = sb.pop_front();
            checkOutput("result", result, e.res);
            checkOutput("zero_flag", zero_flag, e.res == 16'h0000);
            checkOutput("sign_flag", sign_flag, e.res[15]);
            checkOutput("carry_flag", carry_flag, e.c);
            checkOutput("overflow_flag", overflow_flag, e.v);
          end
        end
        prev_valid = rsp_valid;
      end
    end
  end

  // Global time bound
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by a randomized run
  initial begin
    #1;
    checkOutput("reset_result", result, 16'h0000);
    checkOutput("reset_flags", {zero_flag, sign_flag, carry_flag, overflow_flag}, 4'b0000);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("ready_after_reset", req_ready, 1'b1);

    $display("[TB] ADD carry case");
    forced_ready = 1'b1;
    applyStimulus(3'd0, 8'hFF, 8'h01);
    waitDrain();

    $display("[TB] SUB borrow and overflow cases");
    applyStimulus(3'd1, 8'h03, 8'h05);
    waitDrain();
    applyStimulus(3'd1, 8'h80, 8'h01);
    waitDrain();

    $display("[TB] MUL with held request");
    forced_ready = 1'b0;
    applyStimulus(3'd5, 8'hFF, 8'hFF);
    op = 3'd0;
    a = 8'h01;
    b = 8'h01;
    req_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checkOutput("mul_busy", busy, 1'b1);
      checkOutput("mul_req_ready", req_ready, 1'b0);
      checkOutput("mul_hold_result", result, 16'h007F);
      checkOutput("mul_hold_ovf", overflow_flag, 1'b1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checkOutput("mul_not_done_e7", rsp_valid, 1'b0);
    @(posedge clk); #1;
    checkOutput("mul_done_e8", rsp_valid, 1'b1);
    forced_ready = 1'b1;
    waitDrain();

    $display("[TB] XOR zero then MUL by zero");
    applyStimulus(3'd4, 8'h5A, 8'h5A);
    waitDrain();
    applyStimulus(3'd5, 8'h00, 8'h37);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mulz_hold_zero", zero_flag, 1'b1);
      checkOutput("mulz_hold_result", result, 16'h0000);
      @(posedge clk); #1;
    end
    waitDrain();

    $display("[TB] Backpressure");
    forced_ready = 1'b0;
    applyStimulus(3'd0, 8'h10, 8'h20);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_result", result, 16'h0030);
      checkOutput("bp_rsp_valid", rsp_valid, 1'b1);
      checkOutput("bp_req_ready", req_ready, 1'b0);
      @(posedge clk); #1;
    end
    forced_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_ready_after_hs", req_ready, 1'b1);
    checkOutput("bp_valid_after_hs", rsp_valid, 1'b0);
    applyStimulus(3'd3, 8'h0F, 8'hF0);
    checkOutput("b2b_accepted", busy, 1'b1);
    waitDrain();

    $display("[TB] Reserved opcode");
    applyStimulus(3'd6, 8'h12, 8'h34);
    waitDrain();

    $display("[TB] Reset during MUL");
    applyStimulus(3'd5, 8'hAB, 8'hCD);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("abort_result", result, 16'h0000);
    checkOutput("abort_flags", {zero_flag, sign_flag, carry_flag, overflow_flag}, 4'b0000);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_ready", req_ready, 1'b1);
    repeat (15) begin
      @(posedge clk); #1;
    end

    $display("[TB] Randomized run");
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
